// File: rtl/psum_collector.sv
// Collects partial sums from the last PE of a column, buffers them in a small FIFO,
// converts (optional ReLU + saturation) and writes them to consecutive global-buffer addresses.
module psum_collector #(
    parameter int PSUM_W     = 16,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              relu_en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] out_count,
    input  logic              psum_valid,
    input  logic [PSUM_W-1:0] psum_data,
    output logic              psum_ack_out,
    input  logic              gb_wr_ready,
    output logic              gb_wr_en,
    output logic [ADDR_W-1:0] gb_wr_addr,
    output logic [OUT_W-1:0]  gb_wr_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0]     P_ONE  = PW'(1);
    localparam logic [CW-1:0]     C_ONE  = CW'(1);
    localparam logic [CW-1:0]     C_FULL = CW'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
    localparam logic signed [PSUM_W-1:0] SAT_MAX = PSUM_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [PSUM_W-1:0] SAT_MIN = PSUM_W'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Reset asserts immediately but releases only after two clean edges.
    logic [1:0] rst_sync_q;
    logic       arst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign arst_n = rst_sync_q[1];

    state_t            state_q, state_d;
    logic              relu_q, relu_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic              err_q, err_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     occ_q, occ_d;
    logic [PSUM_W-1:0] mem_q [FIFO_DEPTH];

    logic run, fifo_full, fifo_empty, push, pop;

    function automatic logic [OUT_W-1:0] convert(input logic [PSUM_W-1:0] raw, input logic relu);
        logic signed [PSUM_W-1:0] v;
        logic [OUT_W-1:0]         res;
        v = signed'(raw);
        if (relu && v[PSUM_W-1]) res = '0;
        else if (v > SAT_MAX)    res = SAT_MAX[OUT_W-1:0];
        else if (v < SAT_MIN)    res = SAT_MIN[OUT_W-1:0];
        else                     res = v[OUT_W-1:0];
        return res;
    endfunction

    assign run          = (state_q == S_RUN);
    assign fifo_full    = (occ_q == C_FULL);
    assign fifo_empty   = (occ_q == '0);
    assign psum_ack_out = psum_valid && run && !fifo_full && (acc_q < cnt_q);
    assign push         = psum_ack_out;
    assign gb_wr_en     = !fifo_empty && run;
    assign pop          = gb_wr_en && gb_wr_ready;
    assign gb_wr_addr   = base_q + wr_q;
    // Data is forced to zero while empty so reset leaves the bus quiet regardless of RAM contents.
    assign gb_wr_data   = fifo_empty ? '0 : convert(mem_q[rptr_q], relu_q);
    assign busy         = run;
    assign done         = (state_q == S_DONE);
    assign error        = err_q;

    always_comb begin
        state_d = state_q;
        relu_d  = relu_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        wr_d    = wr_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    relu_d  = relu_en;
                    base_d  = base_addr;
                    cnt_d   = out_count;
                    acc_d   = '0;
                    wr_d    = '0;
                    state_d = (out_count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (start) err_d = 1'b1;
                if (push)  acc_d = acc_q + A_ONE;
                if (pop) begin
                    wr_d = wr_q + A_ONE;
                    if (wr_q == cnt_q - A_ONE) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wptr_d = push ? wptr_q + P_ONE : wptr_q;
        rptr_d = pop  ? rptr_q + P_ONE : rptr_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + C_ONE;
            2'b01:   occ_d = occ_q - C_ONE;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            relu_q  <= 1'b0;
            base_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            wr_q    <= '0;
            err_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            relu_q  <= relu_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= psum_data;
    end

endmodule
